// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline hazard detection, operand forwarding and
// multi-cycle mul/div tracking for a five-stage pipeline.
// Optional build macro HAZARD_PERF_EN adds a saturating stall-cycle counter
// on output stall_count.
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] register_s_d,
    input  logic [REG_AW-1:0] register_t_d,
    input  logic [REG_AW-1:0] register_s_e,
    input  logic [REG_AW-1:0] register_t_e,
    input  logic [REG_AW-1:0] register_d_e,
    input  logic [REG_AW-1:0] register_d_m,
    input  logic [REG_AW-1:0] register_d_w,
    input  logic              reg_write_e,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic              wb_source_e,
    input  logic              wb_source_m,
    input  logic              branch_d,
    input  logic              md_op_d,
    input  logic              md_start_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_e,
    output logic              forward_d_0,
    output logic              forward_d_1,
    output logic [1:0]        forward_e_0,
    output logic [1:0]        forward_e_1,
    output logic              md_busy,
    output logic              md_wb,
    output logic [REG_AW-1:0] md_dest
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    localparam logic [3:0] MD_LAT_C = 4'(MD_LAT);

    logic [3:0] md_cnt;
    logic       load_stall;
    logic       branch_stall;
    logic       md_stall;
    logic       any_stall;
    logic       md_accept;

    // Register 0 is hardwired, so it never takes part in a dependency.
    function automatic logic dep(input logic [REG_AW-1:0] src,
                                 input logic [REG_AW-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

    // Execute-stage ALU operand forwarding; the younger M result wins over W.
    always_comb begin
        forward_e_0 = 2'b00;
        forward_e_1 = 2'b00;
        if (reg_write_m && dep(register_s_e, register_d_m))
            forward_e_0 = 2'b01;
        else if (reg_write_w && dep(register_s_e, register_d_w))
            forward_e_0 = 2'b10;
        if (reg_write_m && dep(register_t_e, register_d_m))
            forward_e_1 = 2'b01;
        else if (reg_write_w && dep(register_t_e, register_d_w))
            forward_e_1 = 2'b10;
    end

    // Decode forwarding and stall sources, combined into one pipeline hold.
    always_comb begin
        forward_d_0  = reg_write_m && dep(register_s_d, register_d_m);
        forward_d_1  = reg_write_m && dep(register_t_d, register_d_m);
        load_stall   = wb_source_e && (dep(register_s_d, register_d_e) ||
                                       dep(register_t_d, register_d_e));
        branch_stall = branch_d &&
                       ((reg_write_e && (dep(register_s_d, register_d_e) ||
                                         dep(register_t_d, register_d_e))) ||
                        (wb_source_m && (dep(register_s_d, register_d_m) ||
                                         dep(register_t_d, register_d_m))));
        md_stall     = md_busy && (md_op_d || dep(register_s_d, md_dest) ||
                                   dep(register_t_d, md_dest));
        any_stall    = load_stall || branch_stall || md_stall;
        stall_f      = any_stall;
        stall_d      = any_stall;
        flush_e      = any_stall;
    end

    // Writeback pulse is the last count of the op; a new start may overlap it.
    assign md_wb     = md_busy && (md_cnt == 4'd1);
    assign md_accept = md_start_e && (!md_busy || md_wb);

    // Mul/div tracker: load on accept, count down while busy, drop after wb.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_busy <= 1'b0;
            md_cnt  <= 4'd0;
            md_dest <= '0;
        end else if (md_accept) begin
            md_busy <= 1'b1;
            md_cnt  <= MD_LAT_C;
            md_dest <= register_d_e;
        end else if (md_busy) begin
            md_cnt <= md_cnt - 4'd1;
            if (md_wb)
                md_busy <= 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating count of cycles in which Decode is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_count <= 16'd0;
        else if (stall_d && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
    end
`endif

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter: REG_AW, default 5, register-address width.
REQ-002 Parameter: MD_LAT, default 4, multi-cycle mul/div latency in cycles (legal range 2..15).
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: reset_n  input  1  asynchronous active-low reset.
REQ-005 Port: register_s_d, register_t_d  input  REG_AW  source registers in Decode.
REQ-006 Port: register_s_e, register_t_e, register_d_e  input  REG_AW  sources and destination in Execute.
REQ-007 Port: register_d_m, register_d_w  input  REG_AW  destinations in Memory and Writeback.
REQ-008 Port: reg_write_e, reg_write_m, reg_write_w  input  1  stage writes the register file.
REQ-009 Port: wb_source_e, wb_source_m  input  1  the instruction in E or M is a load.
REQ-010 Port: branch_d  input  1  branch in Decode.
REQ-011 Port: md_op_d  input  1  mul/div in Decode.
REQ-012 Port: md_start_e  input  1  mul/div issuing from Execute.
REQ-013 Port: stall_f, stall_d, flush_e  output  1  pipeline control.
REQ-014 Port: forward_d_0, forward_d_1  output  1  Decode branch-compare forward from M.
REQ-015 Port: forward_e_0, forward_e_1  output  2  Execute ALU forward select: 00 register file, 01 M, 10 W.
REQ-016 Port: md_busy  output  1  mul/div in flight.
REQ-017 Port: md_wb  output  1  one-cycle pulse: mul/div result writes back this cycle.
REQ-018 Port: md_dest  output  REG_AW  destination of the in-flight mul/div.

Function
REQ-019 forward_e_0 SHALL be 01 when register_s_e!=0, register_s_e==register_d_m and reg_write_m; else 10 when register_s_e!=0, register_s_e==register_d_w and reg_write_w; else 00. M has priority over W.
REQ-020 forward_e_1 SHALL follow REQ-019 using register_t_e.
REQ-021 forward_d_0 and forward_d_1 SHALL be 1 when register_s_d or register_t_d respectively is nonzero, equals register_d_m, and reg_write_m is 1.
REQ-022 load_stall SHALL assert when wb_source_e is 1 and register_s_d or register_t_d equals register_d_e, with the matching register nonzero.
REQ-023 branch_stall SHALL assert when branch_d is 1 and either (a) reg_write_e is 1 and a Decode source equals register_d_e, or (b) wb_source_m is 1 and a Decode source equals register_d_m; register 0 never matches.
REQ-024 md_stall SHALL assert when md_busy is 1 and either (a) md_op_d is 1, or (b) a nonzero Decode source equals md_dest.
REQ-025 stall_f, stall_d and flush_e SHALL each equal load_stall OR branch_stall OR md_stall, combinationally.
REQ-026 md_start_e with md_busy at 0 SHALL latch register_d_e into md_dest, load an internal counter with MD_LAT, and set md_busy at the next edge.
REQ-027 While md_busy is 1, the counter SHALL decrement by one each cycle; md_wb SHALL be 1 for exactly the cycle in which the counter equals 1; md_busy SHALL clear at the following edge.
REQ-028 md_start_e while md_busy is 1 is illegal and SHALL be ignored. REQ-024(a) guarantees this case does not occur.
REQ-029 md_start_e in the same cycle that md_wb is 1 SHALL be accepted: the counter reloads to MD_LAT, md_dest updates, and md_busy stays 1.
REQ-030 md_dest SHALL hold its value when md_busy is 0.

Reset
REQ-031 Asserting reset_n low SHALL immediately clear md_busy, md_wb, the counter and md_dest to 0, including while an operation is in flight.
REQ-032 The combinational outputs SHALL reflect their inputs during reset, with md_busy treated as 0.
REQ-033 Deassertion SHALL be sampled synchronously to clk; the first start is accepted at the first rising edge with reset_n high.

Configuration
REQ-034 With HAZARD_PERF_EN defined, the block SHALL add output stall_count (16 bits): reset to 0, incremented at each edge where stall_d is 1, saturating at 16'hFFFF.
REQ-035 With HAZARD_PERF_EN undefined, the stall_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 register_s_e=5, register_d_m=5, reg_write_m=1, register_d_w=5, reg_write_w=1 -> forward_e_0=01; clear reg_write_m -> 10; set register_s_e=0 -> 00.
REQ-037 wb_source_e=1, register_d_e=8, register_t_d=8 -> stall_f=stall_d=flush_e=1 in the same cycle; set register_t_d=0 with register_d_e=0 -> all 0.
REQ-038 branch_d=1, wb_source_m=1, register_d_m=3, register_s_d=3 -> stall asserted; wb_source_m=0 with reg_write_m=1 -> no stall and forward_d_0=1.
REQ-039 MD_LAT=4, md_start_e at cycle 0 with register_d_e=9 -> md_busy=1 over cycles 1..4, md_wb=1 at cycle 4, md_busy=0 at cycle 5; register_s_d=9 stalls during cycles 1..4.
REQ-040 md_start_e during the md_wb cycle -> md_busy stays 1 and a second md_wb arrives MD_LAT cycles later; reset_n pulsed low at cycle 2 of an operation -> md_busy=0 and md_wb never pulses.
REQ-041 With HAZARD_PERF_EN defined and 3 load-use stall cycles -> stall_count=3; force 70000 stall cycles -> stall_count=16'hFFFF.
